seq_comp_sched: RTL and testbench
=================================

Name: seq_comp_sched

Overview:
- Scheduler that shares one bit-serial unsigned comparator between two requesters.
- Round-robin arbitration; the granted operand pair is loaded and shifted MSB-first for N cycles.
- Results are returned with L/E/G flags and a requester ID over a valid/ready response channel.
- Sits in front of the comparator datapath, replacing manual load/op sequencing.

Parameters:
- N, 32, operand width in bits (N >= 2)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, synchronous, active-low
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid
- req0_a  input  N  requester 0 operand A
- req0_b  input  N  requester 0 operand B
- req1_valid  input  1  requester 1 has an operand pair
- req1_ready  output  1  requester 1 accept
- req1_a  input  N  requester 1 operand A
- req1_b  input  N  requester 1 operand B
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_id  output  1  requester that owns the result
- L  output  1  A < B
- E  output  1  A == B
- G  output  1  A > B
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: rst sampled low at a clk edge puts the block in IDLE with count=0, last_grant=1 (so req0 wins first).
  - All outputs are 0, and the shift registers and flags are cleared.
  - Reset mid-operation aborts the comparison; no response is produced.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - Grant logic is combinational: only req0_valid -> grant 0; only req1_valid -> grant 1; both -> grant !last_grant.
  - reqX_ready = (state==IDLE) && grant==X; never both high.
  - At the accept edge: load A/B shift registers from the granted pair, set last_grant=grant and resp_id=grant, clear the decided/L/G flags, set count=0, go to SHIFT.
- SHIFT, each edge:
  - Compare the MSBs (a_msb, b_msb), then shift both registers left by 1 and increment count.
  - If not yet decided and a_msb != b_msb: set G=a_msb, L=b_msb, decided=1.
  - Once decided, later bits are ignored.
  - After the N-th shift edge (count reaches N-1 at that edge), go to RESP.
- RESP:
  - resp_valid=1; E=!decided; L/G/E/resp_id are held stable while resp_valid && !resp_ready.
  - Exactly one of L/E/G is 1.
  - At the edge with resp_valid && resp_ready: go to IDLE; resp_valid and L/E/G drop to 0 in the next cycle.
- Latency: resp_valid rises exactly N cycles after the accept edge.
  - Minimum turnaround is accept -> accept of N+2 cycles when resp_ready is tied high.
- Valid/ready rules:
  - Requesters hold valid and data until accepted.
  - Inputs not granted are ignored.
  - A request that drops valid before acceptance is simply not serviced.
- No new request is accepted while SHIFT or RESP is active: ready=0 in both states.

Optional Feature:
- Macro: SEQ_COMP_SCHED_EARLY_EXIT_EN.
- Defined: in SHIFT, the edge that sets decided goes directly to RESP. Latency = k cycles, where k = 1 + index (from MSB) of the first differing bit. Equal operands still take N cycles.
- Undefined: fixed N-cycle latency as above.

Decomposition:
- Package seq_comp_pkg:
  - FSM state typedef (IDLE/SHIFT/RESP, 2-bit encoding)
  - default width constant 32
  - counter-width function clog2(N)
- Sub-module seq_comp_core:
  - holds the A/B shift registers, decided/L/G flags and the per-bit compare step
  - inputs: load, shift, a_in, b_in
  - outputs: L, E, G, decided
- seq_comp_sched keeps the arbiter, FSM and counter.

Test Plan:
- Single request, resp_ready=1: req0 A=3424522475, B=232242467 -> resp_valid exactly 32 cycles after accept, G=1 L=0 E=0, resp_id=0. With EARLY_EXIT_EN: 1 cycle.
- Equal operands: req1 A=B=3424522475 -> E=1, L=G=0, resp_id=1, latency 32 with or without EARLY_EXIT_EN.
- A<B with backpressure: req0 A=232242467, B=3424522475, resp_ready=0 for 5 cycles after resp_valid -> L=1 held stable, resp_valid stays high, req0_ready/req1_ready stay 0; release -> IDLE next cycle.
- Contention: both valid continuously with distinct pairs (req0 5 vs 9, req1 9 vs 5) -> grants alternate 0,1,0,1; results L then G; no requester starved over 4 responses.
- Reset mid-SHIFT: rst=0 for one edge at cycle 10 of a compare -> next cycle busy=0, resp_valid=0, L=E=G=0; a following req1 is granted first only if req0 is idle, and req0 wins if both are valid (last_grant=1).
- Boundary bits, N=32: A=0x80000000, B=0x7FFFFFFF -> G=1; A=0x00000000, B=0x00000001 -> L=1. With EARLY_EXIT_EN: latencies 1 and 32.

Source files
------------

// File: rtl/seq_comp_pkg.sv
// rtl/seq_comp_pkg.sv - shared width, FSM encoding and counter-width helper for seq_comp_sched
package seq_comp_pkg;

  localparam int unsigned SEQ_COMP_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (((n - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_comp_core.sv
// rtl/seq_comp_core.sv - bit-serial MSB-first unsigned comparator with sticky decision flags
module seq_comp_core
  import seq_comp_pkg::*;
#(
  parameter int unsigned N = SEQ_COMP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         L,
  output logic         E,
  output logic         G,
  output logic         decided,
  output logic         diff_now
);

  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         dec_q, dec_d, l_q, l_d, g_q, g_d;
  logic         a_msb, b_msb;

  assign a_msb    = a_q[N-1];
  assign b_msb    = b_q[N-1];
  // First differing bit from the MSB settles the result; later bits are ignored.
  assign diff_now = shift && !dec_q && (a_msb != b_msb);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    dec_d = dec_q;
    l_d   = l_q;
    g_d   = g_q;
    if (load) begin
      a_d   = a_in;
      b_d   = b_in;
      dec_d = 1'b0;
      l_d   = 1'b0;
      g_d   = 1'b0;
    end else if (shift) begin
      a_d = {a_q[N-2:0], 1'b0};
      b_d = {b_q[N-2:0], 1'b0};
      if (diff_now) begin
        dec_d = 1'b1;
        g_d   = a_msb;
        l_d   = b_msb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      dec_q <= 1'b0;
      l_q   <= 1'b0;
      g_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      dec_q <= dec_d;
      l_q   <= l_d;
      g_q   <= g_d;
    end
  end

  assign L       = l_q;
  assign G       = g_q;
  assign E       = !dec_q;
  assign decided = dec_q;

endmodule

// File: rtl/seq_comp_sched.sv
// rtl/seq_comp_sched.sv - round-robin scheduler sharing one serial comparator; SEQ_COMP_SCHED_EARLY_EXIT_EN ends SHIFT at the first differing bit
module seq_comp_sched
  import seq_comp_pkg::*;
#(
  parameter int unsigned N = SEQ_COMP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic         L,
  output logic         E,
  output logic         G,
  output logic         busy
);

  localparam int unsigned CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_grant_q, last_grant_d;
  logic          resp_id_q, resp_id_d;
  logic          grant, accept, in_idle, in_shift, in_resp;
  logic          core_l, core_e, core_g, core_decided, core_diff;
  logic [N-1:0]  a_sel, b_sel;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_shift = (state_q == ST_SHIFT);
  assign in_resp  = (state_q == ST_RESP);

  // Contention goes to whoever did not win last time.
  assign grant      = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
  assign accept     = in_idle && (req0_valid || req1_valid);
  assign req0_ready = in_idle && req0_valid && !grant;
  assign req1_ready = in_idle && req1_valid && grant;
  assign a_sel      = grant ? req1_a : req0_a;
  assign b_sel      = grant ? req1_b : req0_b;

  seq_comp_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (in_shift),
    .a_in     (a_sel),
    .b_in     (b_sel),
    .L        (core_l),
    .E        (core_e),
    .G        (core_g),
    .decided  (core_decided),
    .diff_now (core_diff)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_SHIFT;
          count_d      = '0;
          last_grant_d = grant;
          resp_id_d    = grant;
        end
      end
      ST_SHIFT: begin
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = ST_RESP;
`ifdef SEQ_COMP_SCHED_EARLY_EXIT_EN
        if (core_diff) state_d = ST_RESP;
`endif
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Flags are only meaningful while a response is presented.
  assign resp_valid = in_resp;
  assign resp_id    = resp_id_q;
  assign L          = in_resp && core_l;
  assign G          = in_resp && core_g;
  assign E          = in_resp && core_e && !core_decided;
  assign busy       = !in_idle;

endmodule

// File: tb/tb_seq_comp_sched.sv
// tb/tb_seq_comp_sched.sv - directed-vector self-checking bench for seq_comp_sched
module tb_seq_comp_sched;

  localparam int N = 32;

`ifdef SEQ_COMP_SCHED_EARLY_EXIT_EN
  localparam int LAT_MSB = 1;
`else
  localparam int LAT_MSB = N;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [N-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          resp_ready = 1'b1;
  logic          req0_ready, req1_ready, resp_valid, resp_id, L, E, G, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_comp_sched #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .L          (L),
    .E          (E),
    .G          (G),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [N-1:0] a, input logic [N-1:0] b);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b;
    end
  endtask

  // One transaction: accept, latency, flags, optional backpressure hold, release.
  task automatic run_op(input string tag, input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int lat, input bit el, input bit ee, input bit eg, input int hold);
    int w;
    int cyc;
    resp_ready = (hold == 0);
    drive_req(id, 1'b1, a, b);
    #1;
    w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      drive_req(id, 1'b0, '0, '0);
      return;
    end
    tick();
    drive_req(id, 1'b0, '0, '0);
    cyc = 0;
    while (!resp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_id"}, resp_id, id);
    chk({tag, "_LEG"}, {L, E, G}, {el, ee, eg});
    if (hold > 0) begin
      drive_req(!id, 1'b1, '0, '0);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "_hold_valid"}, resp_valid, 1);
        chk({tag, "_hold_LEG"}, {L, E, G}, {el, ee, eg});
        chk({tag, "_hold_ready"}, {req0_ready, req1_ready}, 0);
      end
      resp_ready = 1'b1;
    end
    tick();
    drive_req(!id, 1'b0, '0, '0);
    chk({tag, "_drop_valid"}, resp_valid, 0);
    chk({tag, "_drop_busy"}, busy, 0);
    chk({tag, "_drop_LEG"}, {L, E, G}, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int grants[$];
    int r;
    int cyc;

    rst = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_LEG", {L, E, G}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    rst = 1'b1;
    tick();

    run_op("gt", 1'b0, 32'd3424522475, 32'd232242467, LAT_MSB, 1'b0, 1'b0, 1'b1, 0);
    run_op("eq", 1'b1, 32'd3424522475, 32'd3424522475, N, 1'b0, 1'b1, 1'b0, 0);
    run_op("lt_bp", 1'b0, 32'd232242467, 32'd3424522475, LAT_MSB, 1'b1, 1'b0, 1'b0, 5);
    run_op("msb", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, LAT_MSB, 1'b0, 1'b0, 1'b1, 0);
    run_op("lsb", 1'b1, 32'h0000_0000, 32'h0000_0001, N, 1'b1, 1'b0, 1'b0, 0);

    // Contention: restore last_grant=1 so req0 wins first.
    pulse_reset();
    resp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 32'd5, 32'd9);
    drive_req(1'b1, 1'b1, 32'd9, 32'd5);
    #1;
    r = 0;
    cyc = 0;
    while (r < 4 && cyc < 400) begin
      if (req0_ready && req1_ready) chk("both_ready", 1, 0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp_valid) begin
        chk($sformatf("cont_id%0d", r), resp_id, r % 2);
        chk($sformatf("cont_L%0d", r), L, (r % 2) == 0);
        chk($sformatf("cont_G%0d", r), G, (r % 2) == 1);
        r++;
        if (r == 4) begin
          drive_req(1'b0, 1'b0, '0, '0);
          drive_req(1'b1, 1'b0, '0, '0);
        end
      end
      tick();
      cyc++;
    end
    chk("cont_responses", r, 4);
    chk("cont_grant_count", grants.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk($sformatf("cont_grant%0d", i), grants[i], i % 2);
    tick();

    // Reset during SHIFT aborts the compare.
    drive_req(1'b1, 1'b1, 32'd7, 32'd3);
    #1;
    chk("abort_ready", req1_ready, 1);
    tick();
    drive_req(1'b1, 1'b0, '0, '0);
    repeat (9) tick();
    chk("abort_busy_pre", busy, 1);
    pulse_reset();
    chk("abort_busy", busy, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_LEG", {L, E, G}, 0);
    drive_req(1'b0, 1'b1, 32'd1, 32'd2);
    drive_req(1'b1, 1'b1, 32'd2, 32'd1);
    #1;
    chk("abort_both_ready", {req1_ready, req0_ready}, 2'b01);
    drive_req(1'b0, 1'b0, '0, '0);
    #1;
    chk("abort_req1_only", {req1_ready, req0_ready}, 2'b10);
    drive_req(1'b1, 1'b0, '0, '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
